// File: rtl/apple_gen.sv
// Apple position/eat controller for the snake game: eat detection, inc_len growth
// pulse, LFSR relocation and apple pixel classification. Define APPLE_ROUND_EN for clipped corners.
module apple_gen #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          INC_HOLD = 4,
  parameter int          MAX_EATS = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [1:0] game_status,
  output logic       inc_len,
  output logic       apple,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic [7:0] score,
  output logic       full
);

  localparam logic [15:0] SEED_C    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]  HOLD_INIT = 4'(INC_HOLD - 1);
  localparam logic [1:0]  PLAY      = 2'b10;
  localparam logic [5:0]  RST_AX    = 6'd24;
  localparam logic [5:0]  RST_AY    = 6'd10;

  typedef enum logic [1:0] {IDLE, EAT, GAP, RELOC} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  hold_q;
  logic [7:0]  score_q;
  logic [5:0]  apple_x_q, apple_y_q;
  logic        inc_len_q;
  logic [5:0]  cand_x, cand_y;
  logic        cand_ok, eat_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cand_x = lfsr_q[5:0];
    cand_y = {1'b0, lfsr_q[12:8]};
    cand_ok = (cand_x >= 6'd1) && (cand_x <= 6'd38) &&
              (cand_y >= 6'd1) && (cand_y <= 6'd28) &&
              ({cand_x, cand_y} != {head_x, head_y}) &&
              ({cand_x, cand_y} != {apple_x_q, apple_y_q});
    eat_hit = (game_status == PLAY) && !full &&
              ({head_x, head_y} == {apple_x_q, apple_y_q});
  end

  assign full = (32'(score_q) >= 32'(MAX_EATS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_C;
      hold_q    <= 4'd0;
      score_q   <= 8'd0;
      apple_x_q <= RST_AX;
      apple_y_q <= RST_AY;
      inc_len_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (eat_hit) begin
            state_q   <= EAT;
            hold_q    <= HOLD_INIT;
            score_q   <= sat_inc(score_q);
            inc_len_q <= 1'b1;
          end
        end
        EAT: begin
          if (hold_q == 4'd0) begin
            state_q   <= GAP;
            inc_len_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        // one low cycle lets the snake's add-cube handshake re-arm
        GAP: state_q <= RELOC;
        RELOC: begin
          if (cand_ok) begin
            apple_x_q <= cand_x;
            apple_y_q <= cand_y;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic       in_cell;
  logic [3:0] lx, ly;
  logic       mask_ok;

  always_comb begin
    lx      = x_pos[3:0];
    ly      = y_pos[3:0];
    in_cell = (x_pos < 10'd640) && (y_pos < 10'd480) &&
              (x_pos[9:4] == apple_x_q) && (y_pos[9:4] == apple_y_q);
`ifdef APPLE_ROUND_EN
    mask_ok = !(((lx < 4'd2) || (lx > 4'd13)) && ((ly < 4'd2) || (ly > 4'd13)));
`else
    mask_ok = 1'b1;
`endif
  end

  assign apple   = in_cell && mask_ok;
  assign inc_len = inc_len_q;
  assign apple_x = apple_x_q;
  assign apple_y = apple_y_q;
  assign score   = score_q;

endmodule

// File: tb/tb_apple_gen.sv
// Directed self-checking bench for apple_gen: reset state, eat pulse timing,
// game_status gating, mid-eat reset, saturation at full, and pixel classification.
module tb_apple_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pos, y_pos;
  logic [5:0] head_x, head_y;
  logic [1:0] game_status;
  logic       inc_len, apple, full;
  logic [5:0] apple_x, apple_y;
  logic [7:0] score;

  int n_cmp = 0;
  int n_mis = 0;

  apple_gen dut (
    .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .head_x(head_x), .head_y(head_y), .game_status(game_status),
    .inc_len(inc_len), .apple(apple), .apple_x(apple_x), .apple_y(apple_y),
    .score(score), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for the apple to move away from (ox,oy); bounded
  task automatic wait_reloc(input int ox, input int oy);
    int n = 0;
    while ((apple_x == 6'(ox)) && (apple_y == 6'(oy)) && (n < 500)) begin
      step();
      n++;
    end
    check_eq("reloc_done", (n < 500) ? 1 : 0, 1);
  endtask

  task automatic check_apple_legal(input int ox, input int oy);
    check_eq("ax_range", (apple_x >= 1 && apple_x <= 38) ? 1 : 0, 1);
    check_eq("ay_range", (apple_y >= 1 && apple_y <= 28) ? 1 : 0, 1);
    check_eq("moved", ({apple_x, apple_y} != {6'(ox), 6'(oy)}) ? 1 : 0, 1);
  endtask

  int exp_corner;
  int ones;

  initial begin
    reset = 1'b0; x_pos = '0; y_pos = '0;
    head_x = 6'd10; head_y = 6'd5; game_status = 2'b10;
    step(); step();
    check_eq("rst_ax", apple_x, 24);
    check_eq("rst_ay", apple_y, 10);
    check_eq("rst_inc", inc_len, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_full", full, 0);

`ifdef APPLE_ROUND_EN
    exp_corner = 0;
`else
    exp_corner = 1;
`endif
    x_pos = 10'd384; y_pos = 10'd160; #1 check_eq("pix_corner00", apple, exp_corner);
    x_pos = 10'd399; y_pos = 10'd175; #1 check_eq("pix_corner1515", apple, exp_corner);
    x_pos = 10'd392; y_pos = 10'd168; #1 check_eq("pix_center", apple, 1);
    x_pos = 10'd384; y_pos = 10'd168; #1 check_eq("pix_edge", apple, 1);
    x_pos = 10'd400; y_pos = 10'd168; #1 check_eq("pix_next_cell", apple, 0);
    x_pos = 10'd392; y_pos = 10'd150; #1 check_eq("pix_row_above", apple, 0);

    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check_eq("idle_inc", inc_len, 0);
      check_eq("idle_score", score, 0);
      check_eq("idle_ax", apple_x, 24);
      check_eq("idle_ay", apple_y, 10);
    end

    // head on apple but not PLAY: no eat
    head_x = 6'd24; head_y = 6'd10; game_status = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("nplay_inc", inc_len, 0);
      check_eq("nplay_score", score, 0);
    end
    game_status = 2'b10;
    step();
    check_eq("eat_inc_first", inc_len, 1);
    check_eq("eat_score", score, 1);
    // head leaves mid-pulse; pulse length must be unaffected
    head_x = 6'd10; head_y = 6'd5;
    ones = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      ones += inc_len;
      check_eq("eat_ax_hold", apple_x, 24);
    end
    check_eq("eat_pulse_len", ones, 4);
    step();
    check_eq("gap_inc", inc_len, 0);
    wait_reloc(24, 10);
    check_apple_legal(24, 10);
    check_eq("not_head", ({apple_x, apple_y} != {6'd10, 6'd5}) ? 1 : 0, 1);
    check_eq("score_after", score, 1);

    // reset during the second EAT cycle
    reset = 1'b0; step();
    check_eq("rst2_ax", apple_x, 24);
    check_eq("rst2_score", score, 0);
    head_x = 6'd24; head_y = 6'd10; reset = 1'b1;
    step();
    check_eq("rst2_inc1", inc_len, 1);
    check_eq("rst2_score1", score, 1);
    step();
    check_eq("rst2_inc2", inc_len, 1);
    reset = 1'b0;
    step();
    check_eq("midrst_inc", inc_len, 0);
    check_eq("midrst_score", score, 0);
    check_eq("midrst_ax", apple_x, 24);
    check_eq("midrst_ay", apple_y, 10);
    head_x = 6'd10; head_y = 6'd5; reset = 1'b1;
    step();
    check_eq("midrst_noreplay", inc_len, 0);

    // drive 13 eats by chasing the apple
    for (int k = 0; k < 13; k++) begin
      int ox, oy;
      check_eq("pre_full", full, 0);
      ox = apple_x; oy = apple_y;
      head_x = apple_x; head_y = apple_y;
      step();
      check_eq("chase_inc", inc_len, 1);
      check_eq("chase_score", score, k + 1);
      wait_reloc(ox, oy);
      check_apple_legal(ox, oy);
    end
    check_eq("full_score", score, 13);
    check_eq("full_flag", full, 1);
    head_x = apple_x; head_y = apple_y;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("full_no_inc", inc_len, 0);
    end
    check_eq("full_score_hold", score, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/apple_gen.md
# apple_gen

Food-side partner of the snake datapath: owns the apple's grid position and drives the `inc_len` growth handshake that the snake module consumes. It watches `head_x`/`head_y`, detects an eat in PLAY state, and pulses `inc_len`. It then relocates the apple to a pseudo-random legal cell. It also classifies the current VGA pixel as apple or not, for the pixel mux alongside the snake's `snake[1:0]`.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1.
- `INC_HOLD`, default 4: number of cycles `inc_len` is held high per eat; legal range 1–15.
- `MAX_EATS`, default 13: eats accepted before `full` asserts. 13 fills a 16-cube snake from a starting length of 3.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-low.
- `x_pos` in 10: VGA pixel column.
- `y_pos` in 10: VGA pixel row.
- `head_x` in 6: snake head cell column.
- `head_y` in 6: snake head cell row.
- `game_status` in 2: game state; PLAY = 2'b10.
- `inc_len` out 1: growth request to the snake, level-held.
- `apple` out 1: current pixel lies inside the apple.
- `apple_x` out 6: apple cell column.
- `apple_y` out 6: apple cell row.
- `score` out 8: eat count.
- `full` out 1: `score` ≥ `MAX_EATS`; no further eats are accepted.

## Operation
- Playfield cells: x 1..38, y 1..28. Walls occupy x=0, x=39, y=0, y=29.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle while `reset`=1.
  - Candidate position: cx=`lfsr[5:0]`, cy=`lfsr[12:8]` (zero-extended to 6 bits).
- FSM states: IDLE, EAT, GAP, RELOC.
- IDLE:
  - Exit condition: `game_status`==PLAY, `full`=0, and {`head_x`,`head_y`}=={`apple_x`,`apple_y`}.
  - On exit, go to EAT, load the hold counter with `INC_HOLD`-1, and increment `score` (saturating at 255).
- EAT:
  - `inc_len`=1.
  - Hold counter decrements each cycle; at 0, go to GAP.
- GAP:
  - `inc_len`=0 for exactly 1 cycle, so the snake's add-cube handshake re-arms.
  - Then go to RELOC.
- RELOC:
  - Each cycle, test the candidate.
  - Accept when 1≤cx≤38, 1≤cy≤28, candidate ≠ head, and candidate ≠ current apple.
  - On accept, load `apple_x`/`apple_y` and go to IDLE. On reject, stay in RELOC; the next cycle uses the next LFSR value.
- An eat sequence (EAT→GAP→RELOC) always runs to completion regardless of `game_status`.
- `full`: combinational compare of `score` against `MAX_EATS`. While `full`=1, IDLE never exits.
- `apple` (combinational) is 1 when all of the following hold:
  - `x_pos`<640 and `y_pos`<480.
  - `x_pos[9:4]`==`apple_x` and `y_pos[9:4]`==`apple_y`.
  - The shape mask passes (see Configuration).
- The snake is not sampled for body overlap; the apple may appear under a body cube (accepted game behaviour).

## Timing
- Reset values: `apple_x`=24, `apple_y`=10, `inc_len`=0, `score`=0, state=IDLE, LFSR=`SEED`. `full`=0 unless `MAX_EATS`=0.
- Eat latency:
  - A head match sampled at edge N puts the FSM in EAT after edge N.
  - `inc_len` is high for cycles N+1..N+`INC_HOLD`, low at N+`INC_HOLD`+1 (GAP).
  - RELOC begins at N+`INC_HOLD`+2.
- RELOC duration: ≥1 cycle, unbounded in principle. With default `SEED` it is ≤64 cycles in practice, far below the snake step period of 12.5M cycles.
- `apple_x`/`apple_y` change only at the RELOC accept edge. `score` changes only at the IDLE→EAT edge.
- Reset asserted mid-sequence: next edge returns all state to reset values and drops `inc_len` immediately. No partial increment is replayed.
- Head leaving the apple during EAT does not shorten the pulse.

## Configuration
- `APPLE_ROUND_EN` defined: rounded apple.
  - Pixels with local offset lx=`x_pos[3:0]`, ly=`y_pos[3:0]` are excluded when (lx<2 or lx>13) and (ly<2 or ly>13), i.e. 2×2 corners are clipped.
- Undefined: the full 16×16 cell is drawn. Position logic is identical in both builds.

## Test plan
- Reset, then hold head=(10,5), PLAY for 100 cycles -> `apple_x`=24, `apple_y`=10, `inc_len`=0, `score`=0 throughout.
- Head=(24,10), PLAY at edge N -> `inc_len`=1 for exactly 4 cycles, `score`=1, new apple within 1..38 × 1..28 and ≠ (24,10).
- Head=(24,10) with `game_status`=2'b01 -> no `inc_len`, `score` stays 0; switch to PLAY -> eat sequence starts on the next edge.
- Assert `reset`=0 in the 2nd cycle of EAT -> `inc_len`=0 and `score`=0 the next cycle, apple back at (24,10).
- Drive 13 eats by tracking `apple_x`/`apple_y` -> `full`=1, `score`=13; head on apple again -> no `inc_len`.
- `x_pos`=384, `y_pos`=160 (local 0,0 of cell 24,10) -> `apple`=1 without `APPLE_ROUND_EN`, 0 with it. `x_pos`=392, `y_pos`=168 -> 1 in both builds.
